td4_exec_ctrl: RTL and testbench
================================

// Module: td4_exec_ctrl
// PURPOSE
//  Execution controller for the TD4 4-bit CPU core. Produces the core's clock enable in three modes:
//  free-running with a divided tick, single-step, or halted. Stops on a breakpoint. While halted, it
//  owns the 16x8 program RAM write port so a host can load programs. Sits between board buttons/host
//  link and the CPU core; the core's registers advance only when cpu_ce=1.
// PARAMETERS
//  TICK_DIV   12000000  clock cycles per instruction in RUN mode; legal range >=1 (1 = every cycle)
//  CNT_W      24        tick counter width; must hold TICK_DIV-1
//  ADDR_W     4         program address width (16 words)
//  DATA_W     8         program word width ({OP[3:0],Imm[3:0]})
// PORTS
//  clock       in   1       system clock, all logic on rising edge
//  reset       in   1       asynchronous, active-low; clears all state
//  cmd_run     in   1       1-cycle pulse: start free-running
//  cmd_step    in   1       1-cycle pulse: execute exactly one instruction
//  cmd_halt    in   1       1-cycle pulse: stop
//  cmd_clr     in   1       1-cycle pulse: reset CPU core, enter HALT
//  bp_en       in   1       breakpoint enable
//  bp_addr     in   ADDR_W  breakpoint instruction address
//  cpu_ip      in   ADDR_W  current instruction pointer from the core
//  prog_valid  in   1       host write request
//  prog_ready  out  1       controller accepts a write this cycle
//  prog_addr   in   ADDR_W  write address
//  prog_data   in   DATA_W  write data
//  cpu_ce      out  1       registered clock enable to the core (1-cycle pulses)
//  cpu_rst_n   out  1       registered active-low synchronous reset to the core
//  ram_we      out  1       registered program RAM write strobe
//  ram_addr    out  ADDR_W  registered RAM write address
//  ram_wdata   out  DATA_W  registered RAM write data
//  running     out  1       1 while state==RUN
//  bp_hit      out  1       1-cycle pulse when a breakpoint stops RUN
//  instr_cnt   out  8       count of cpu_ce pulses; wraps 255->0; cleared by cmd_clr
// BEHAVIOUR
//  Reset values: state HALT, cpu_ce=0, cpu_rst_n=0 for the first cycle after reset release and then 1,
//   ram_we=0, ram_addr=0, ram_wdata=0, bp_hit=0, instr_cnt=0, tick counter=0, first_tick=1.
//  States: HALT, RUN, STEP, WRITE. prog_ready = (state==HALT) && cpu_rst_n && !any cmd_* this cycle.
//  Command priority in the same cycle: cmd_clr > cmd_halt > cmd_step > cmd_run. prog_valid is lowest.
//  cmd_clr, any state: cpu_rst_n=0 next cycle for exactly 1 cycle; state->HALT; instr_cnt=0;
//   a WRITE in progress completes (ram_we already registered).
//  HALT: cmd_step->STEP; cmd_run->RUN (counter=0, first_tick=1); prog_valid&&prog_ready->WRITE.
//  STEP: cpu_ce=1 for one cycle (cycle n+1 after cmd_step in cycle n); state->HALT in cycle n+2.
//   Breakpoint is ignored.
//  WRITE: ram_we=1 with latched addr/data for exactly 1 cycle; ->HALT. All commands are dropped.
//  RUN: counter increments each cycle. At counter==TICK_DIV-1: counter->0 and a tick occurs.
//   If bp_en && cpu_ip==bp_addr && !first_tick: no cpu_ce, bp_hit=1, state->HALT (break before
//   execute). Otherwise cpu_ce=1 and first_tick->0. cmd_halt: state->HALT, no further cpu_ce,
//   counter->0. cmd_run/cmd_step in RUN are ignored.
//  The first cpu_ce after cmd_run in cycle n is in cycle n+TICK_DIV+1. Spacing is then TICK_DIV cycles.
//  instr_cnt increments on every cycle with cpu_ce=1 (modulo 256).
//  prog_valid while prog_ready=0: the host holds the request; nothing is written.
//  Reset asserted mid-RUN or mid-WRITE: immediate return to reset values; the partial write is lost.
// STRUCTURE
//  Shared include td4_defs.vh: state encodings (HALT=2'd0, RUN=2'd1, STEP=2'd2, WRITE=2'd3),
//   TD4_ADDR_W=4, TD4_DATA_W=8.
//  Sub-module td4_tick_div (parameterised TICK_DIV/CNT_W; inputs clear/enable; output tick).
//   The FSM, breakpoint compare, write port and counter live in td4_exec_ctrl.
// TESTING (TICK_DIV=4 unless stated)
//  1 Release reset, idle 5 cycles -> cpu_rst_n 0 then 1; cpu_ce=0 throughout; prog_ready=1.
//  2 prog_valid addr=3 data=8'hB5 -> ram_we=1 one cycle, ram_addr=3, ram_wdata=B5; prog_ready=0
//    that cycle; a second request is accepted 2 cycles later.
//  3 cmd_step in cycle n -> cpu_ce=1 only in n+1; instr_cnt=1; running=0.
//  4 cmd_run, 3 ticks -> cpu_ce in cycles n+5, n+9, n+13; cmd_halt -> no further cpu_ce; instr_cnt=3.
//  5 bp_en=1, bp_addr=2, cpu_ip model increments on cpu_ce from 0 -> two cpu_ce, then bp_hit at the
//    third tick, state HALT; cmd_run again -> the next tick executes (first_tick bypass).
//  6 cmd_clr+cmd_run same cycle mid-RUN -> cpu_rst_n low 1 cycle, HALT, instr_cnt=0, no cpu_ce.

Source files
------------

// File: rtl/td4_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// td4_exec_ctrl_pkg : shared widths and controller state encoding
// Rev 1.0
// ============================================================================
package td4_exec_ctrl_pkg;

    localparam int TD4_ADDR_W = 4;
    localparam int TD4_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_WRITE = 2'd3
    } exec_state_e;

endpackage
`default_nettype wire

// File: rtl/td4_exec_ctrl_tick_div.sv
`default_nettype none
// ============================================================================
// td4_exec_ctrl_tick_div : instruction-rate divider, one tick every TICK_DIV enabled cycles
// Rev 1.0
// ============================================================================
module td4_exec_ctrl_tick_div #(
    parameter int TICK_DIV = 12000000,
    parameter int CNT_W    = 24
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == C_LAST);

    // Clear wins so the count restarts from zero whenever RUN is (re)entered.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : (cnt_q + C_ONE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/td4_exec_ctrl.sv
`default_nettype none
// ============================================================================
// td4_exec_ctrl : TD4 core clock-enable controller (run / step / halt, breakpoint, program load)
// Rev 1.0
// ============================================================================
module td4_exec_ctrl
    import td4_exec_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 12000000,
    parameter int CNT_W    = 24,
    parameter int ADDR_W   = TD4_ADDR_W,
    parameter int DATA_W   = TD4_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_run_i,
    input  logic              cmd_step_i,
    input  logic              cmd_halt_i,
    input  logic              cmd_clr_i,
    input  logic              bp_en_i,
    input  logic [ADDR_W-1:0] bp_addr_i,
    input  logic [ADDR_W-1:0] cpu_ip_i,
    input  logic              prog_valid_i,
    output logic              prog_ready_o,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    output logic              cpu_ce_o,
    output logic              cpu_rst_n_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              running_o,
    output logic              bp_hit_o,
    output logic [7:0]        instr_cnt_o
);

    exec_state_e       state_q, state_d;
    logic              cpu_ce_q, cpu_ce_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              bp_hit_q, bp_hit_d;
    logic [7:0]        instr_cnt_q, instr_cnt_d;
    logic              first_tick_q, first_tick_d;

    logic              tick;
    logic              any_cmd;
    logic              bp_match;

    td4_exec_ctrl_tick_div #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_div (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (state_d != ST_RUN),
        .enable_i (state_q == ST_RUN),
        .tick_o   (tick)
    );

    assign any_cmd      = cmd_run_i | cmd_step_i | cmd_halt_i | cmd_clr_i;
    assign prog_ready_o = (state_q == ST_HALT) && cpu_rst_n_q && !any_cmd;
    // The instruction that was just resumed from must not re-trigger its own breakpoint.
    assign bp_match     = bp_en_i && (cpu_ip_i == bp_addr_i) && !first_tick_q;

    always_comb begin
        state_d      = state_q;
        cpu_ce_d     = 1'b0;
        cpu_rst_n_d  = 1'b1;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        bp_hit_d     = 1'b0;
        first_tick_d = first_tick_q;
        instr_cnt_d  = instr_cnt_q + {7'd0, cpu_ce_q};

        if (cmd_clr_i) begin
            cpu_rst_n_d = 1'b0;
            state_d     = ST_HALT;
            instr_cnt_d = '0;
        end else begin
            case (state_q)
                ST_HALT: begin
                    if (cmd_halt_i) begin
                        state_d = ST_HALT;
                    end else if (cmd_step_i) begin
                        state_d  = ST_STEP;
                        cpu_ce_d = 1'b1;
                    end else if (cmd_run_i) begin
                        state_d      = ST_RUN;
                        first_tick_d = 1'b1;
                    end else if (prog_valid_i && prog_ready_o) begin
                        state_d     = ST_WRITE;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = prog_addr_i;
                        ram_wdata_d = prog_data_i;
                    end
                end
                ST_RUN: begin
                    if (cmd_halt_i) begin
                        state_d = ST_HALT;
                    end else if (tick) begin
                        if (bp_match) begin
                            bp_hit_d = 1'b1;
                            state_d  = ST_HALT;
                        end else begin
                            cpu_ce_d     = 1'b1;
                            first_tick_d = 1'b0;
                        end
                    end
                end
                ST_STEP:  state_d = ST_HALT;
                ST_WRITE: state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_HALT;
            cpu_ce_q     <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            bp_hit_q     <= 1'b0;
            instr_cnt_q  <= '0;
            first_tick_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cpu_ce_q     <= cpu_ce_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            bp_hit_q     <= bp_hit_d;
            instr_cnt_q  <= instr_cnt_d;
            first_tick_q <= first_tick_d;
        end
    end

    assign cpu_ce_o    = cpu_ce_q;
    assign cpu_rst_n_o = cpu_rst_n_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign running_o   = (state_q == ST_RUN);
    assign bp_hit_o    = bp_hit_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_td4_exec_ctrl.sv
`default_nettype none
// ============================================================================
// tb_td4_exec_ctrl : directed + random bench for td4_exec_ctrl against a behavioural model
// Rev 1.0
// ============================================================================
module tb_td4_exec_ctrl;

    localparam int TD = 4;
    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_WRITE = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_run, cmd_step, cmd_halt, cmd_clr;
    logic       bp_en;
    logic [3:0] bp_addr, cpu_ip, prog_addr;
    logic [7:0] prog_data;
    logic       prog_valid;
    wire        prog_ready, cpu_ce, cpu_rst_n, ram_we, running, bp_hit;
    wire  [3:0] ram_addr;
    wire  [7:0] ram_wdata, instr_cnt;
    wire        prog_ready1, cpu_ce1, cpu_rst_n1, ram_we1, running1, bp_hit1;
    wire  [3:0] ram_addr1;
    wire  [7:0] ram_wdata1, instr_cnt1;

    always #5 clk = ~clk;

    td4_exec_ctrl #(.TICK_DIV(TD), .CNT_W(3), .ADDR_W(4), .DATA_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cmd_run_i(cmd_run), .cmd_step_i(cmd_step),
        .cmd_halt_i(cmd_halt), .cmd_clr_i(cmd_clr), .bp_en_i(bp_en), .bp_addr_i(bp_addr),
        .cpu_ip_i(cpu_ip), .prog_valid_i(prog_valid), .prog_ready_o(prog_ready),
        .prog_addr_i(prog_addr), .prog_data_i(prog_data), .cpu_ce_o(cpu_ce),
        .cpu_rst_n_o(cpu_rst_n), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .running_o(running), .bp_hit_o(bp_hit),
        .instr_cnt_o(instr_cnt)
    );

    td4_exec_ctrl #(.TICK_DIV(1), .CNT_W(1), .ADDR_W(4), .DATA_W(8)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cmd_run_i(cmd_run), .cmd_step_i(cmd_step),
        .cmd_halt_i(cmd_halt), .cmd_clr_i(cmd_clr), .bp_en_i(bp_en), .bp_addr_i(bp_addr),
        .cpu_ip_i(cpu_ip), .prog_valid_i(prog_valid), .prog_ready_o(prog_ready1),
        .prog_addr_i(prog_addr), .prog_data_i(prog_data), .cpu_ce_o(cpu_ce1),
        .cpu_rst_n_o(cpu_rst_n1), .ram_we_o(ram_we1), .ram_addr_o(ram_addr1),
        .ram_wdata_o(ram_wdata1), .running_o(running1), .bp_hit_o(bp_hit1),
        .instr_cnt_o(instr_cnt1)
    );

    // Stand-in for the core's instruction pointer
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cpu_ip <= 4'd0;
        else if (!cpu_rst_n) cpu_ip <= 4'd0;
        else if (cpu_ce)     cpu_ip <= cpu_ip + 4'd1;
    end

    int         checks = 0;
    int         failures = 0;
    int         ce_seen, bp_seen;
    int         m_mode;
    longint     cyc, m_next_tick;
    bit         m_first;
    bit         e_ce, e_rstn, e_we, e_bp;
    logic [3:0] e_addr;
    logic [7:0] e_wdata, e_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_mode == M_HALT) && e_rstn && !(cmd_run | cmd_step | cmd_halt | cmd_clr);
    endfunction

    task automatic model_reset();
        m_mode = M_HALT; m_first = 1'b1; cyc = 0; m_next_tick = 0;
        e_ce = 0; e_rstn = 0; e_we = 0; e_bp = 0;
        e_addr = '0; e_wdata = '0; e_instr = '0;
    endtask

    // Applies the controller's rules for one clock using the inputs present now.
    task automatic model_step();
        bit         ready;
        logic [7:0] n_instr;
        ready   = m_ready();
        n_instr = e_instr + 8'(e_ce);
        e_ce = 0; e_bp = 0; e_we = 0; e_rstn = 1; e_instr = n_instr;
        if (cmd_clr) begin
            e_rstn = 0; e_instr = '0; m_mode = M_HALT;
        end else if (m_mode == M_HALT) begin
            if (cmd_halt) begin
                m_mode = M_HALT;
            end else if (cmd_step) begin
                m_mode = M_STEP; e_ce = 1;
            end else if (cmd_run) begin
                m_mode = M_RUN; m_first = 1; m_next_tick = cyc + TD;
            end else if (prog_valid && ready) begin
                m_mode = M_WRITE; e_we = 1; e_addr = prog_addr; e_wdata = prog_data;
            end
        end else if (m_mode == M_RUN) begin
            if (cmd_halt) begin
                m_mode = M_HALT;
            end else if (cyc == m_next_tick) begin
                m_next_tick = m_next_tick + TD;
                if (bp_en && cpu_ip == bp_addr && !m_first) begin
                    e_bp = 1; m_mode = M_HALT;
                end else begin
                    e_ce = 1; m_first = 0;
                end
            end
        end else begin
            m_mode = M_HALT;
        end
        cyc++;
    endtask

    task automatic compare_all();
        chk("cpu_ce", cpu_ce, e_ce);
        chk("cpu_rst_n", cpu_rst_n, e_rstn);
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wdata", ram_wdata, e_wdata);
        chk("running", running, m_mode == M_RUN);
        chk("bp_hit", bp_hit, e_bp);
        chk("instr_cnt", instr_cnt, e_instr);
    endtask

    // Called just after a falling edge with this cycle's inputs already applied.
    task automatic cycle();
        #1;
        chk("prog_ready", prog_ready, m_ready());
        model_step();
        @(negedge clk);
        compare_all();
        ce_seen += int'(cpu_ce);
        bp_seen += int'(bp_hit);
        cmd_run = 0; cmd_step = 0; cmd_halt = 0; cmd_clr = 0;
    endtask

    initial begin
        rst_n = 0; cmd_run = 0; cmd_step = 0; cmd_halt = 0; cmd_clr = 0;
        bp_en = 0; bp_addr = 0; prog_valid = 0; prog_addr = 0; prog_data = 0;
        ce_seen = 0; bp_seen = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_prog_ready", prog_ready, 1'b0);
        rst_n = 1;

        // Idle after reset release
        repeat (5) cycle();
        #1 chk("t1_prog_ready", prog_ready, 1'b1);

        // Program write, request held across the busy cycle
        @(negedge clk);
        prog_valid = 1; prog_addr = 4'd3; prog_data = 8'hB5;
        cycle();
        chk("t2_we", ram_we, 1'b1);
        chk("t2_addr", ram_addr, 4'd3);
        chk("t2_wdata", ram_wdata, 8'hB5);
        #1 chk("t2_ready_busy", prog_ready, 1'b0);
        prog_addr = 4'd4; prog_data = 8'h3C;
        cycle();
        chk("t2_no_write", ram_we, 1'b0);
        cycle();
        chk("t2_second", ram_we, 1'b1);
        chk("t2_second_data", ram_wdata, 8'h3C);
        prog_valid = 0;
        cycle();

        // Single step
        cmd_step = 1;
        cycle();
        chk("t3_ce", cpu_ce, 1'b1);
        chk("t3_running", running, 1'b0);
        cycle();
        chk("t3_ce_once", cpu_ce, 1'b0);
        chk("t3_cnt", instr_cnt, 8'd1);
        chk("t3_ce_div1", cpu_ce1, 1'b0);

        // Free run, three ticks, then halt (second instance runs at TICK_DIV=1)
        cmd_run = 1;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            chk("t4_ce", cpu_ce, (k == 5 || k == 9 || k == 13));
            chk("t4_ce_div1", cpu_ce1, k >= 2);
        end
        cmd_halt = 1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("t4_halted_ce", cpu_ce, 1'b0);
        end
        chk("t4_cnt", instr_cnt, 8'd4);

        // Breakpoint at address 2 from a cleared core
        cmd_clr = 1;
        repeat (3) cycle();
        bp_en = 1; bp_addr = 4'd2; ce_seen = 0; bp_seen = 0;
        cmd_run = 1;
        repeat (20) cycle();
        chk("t5_ce_count", ce_seen, 2);
        chk("t5_bp_count", bp_seen, 1);
        chk("t5_halted", running, 1'b0);
        chk("t5_ip", cpu_ip, 4'd2);
        cmd_run = 1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk("t5_resume_ce", cpu_ce, k == 5);
        end
        cmd_halt = 1;
        cycle();
        bp_en = 0;

        // Clear and run together mid-RUN
        cmd_run = 1;
        repeat (6) cycle();
        cmd_clr = 1; cmd_run = 1;
        cycle();
        chk("t6_rst_low", cpu_rst_n, 1'b0);
        chk("t6_halt", running, 1'b0);
        chk("t6_cnt", instr_cnt, 8'd0);
        ce_seen = 0;
        repeat (8) cycle();
        chk("t6_rst_high", cpu_rst_n, 1'b1);
        chk("t6_no_ce", ce_seen, 0);

        // Randomised commands, breakpoints and host writes
        for (int i = 0; i < 1500; i++) begin
            cmd_clr  = ($urandom_range(0, 60) == 0);
            cmd_halt = ($urandom_range(0, 40) == 0);
            cmd_step = ($urandom_range(0, 20) == 0);
            cmd_run  = ($urandom_range(0, 12) == 0);
            if ($urandom_range(0, 50) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 30) == 0) bp_addr = 4'($urandom);
            if (!prog_valid && $urandom_range(0, 3) == 0) begin
                prog_valid = 1; prog_addr = 4'($urandom); prog_data = 8'($urandom);
            end
            if (prog_valid && m_ready()) begin
                cycle();
                prog_valid = 0;
            end else begin
                cycle();
            end
        end

        // Asynchronous reset during a write
        prog_valid = 1; prog_addr = 4'd9; prog_data = 8'h5A;
        cycle();
        prog_valid = 0;
        #2 rst_n = 0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        rst_n = 1;
        repeat (3) cycle();

        // Asynchronous reset during RUN
        cmd_run = 1;
        repeat (7) cycle();
        #2 rst_n = 0;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        rst_n = 1;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
